// File: rtl/bit_serializer_pkg.sv
// Shared definitions for the word-to-bit serializer: FSM state encoding
// and the default idle level on the serial line.
package bit_serializer_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam logic IDLE_BIT_DEFAULT = 1'b0;

endpackage

// File: rtl/word_hold_reg.sv
// Single-entry holding register that parks the next word while the
// shifter is busy. A write and a read in the same cycle is only legal
// while full; the new word then replaces the drained one and full stays set.
module word_hold_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full
);

  logic             r_full;
  logic [WIDTH-1:0] r_data;

  // Occupancy flag: set on write, cleared on read, kept on simultaneous write+read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_full <= 1'b0;
    end else begin
      r_full <= wr_en | (r_full & ~rd_en);
    end
  end

  // Data storage; the contents only matter while r_full is set, so no reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      r_data <= wr_data;
    end
  end

  assign rd_data = r_data;
  assign full    = r_full;

endmodule

// File: rtl/bit_serializer.sv
// Word-to-bit serializer feeding the 101 sequence detector.
// Accepts WIDTH-bit words on a valid/ready handshake, holds one pending
// word, and shifts one bit per clock onto serial_bit with no gap between
// back-to-back words.
// Optional build macro: BIT_SERIALIZER_LSB_FIRST_EN selects LSB-first
// shift order; when undefined the word is sent MSB first.
module bit_serializer
  import bit_serializer_pkg::*;
#(
  parameter int   WIDTH    = 8,
  parameter logic IDLE_BIT = IDLE_BIT_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         load_data,
  input  logic                     load_valid,
  output logic                     load_ready,
  output logic                     serial_bit,
  output logic                     serial_valid,
  output logic                     serial_last,
  output logic [$clog2(WIDTH)-1:0] bit_index
);

  localparam int               CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);
`ifdef BIT_SERIALIZER_LSB_FIRST_EN
  localparam int               OUT_POS  = 0;
`else
  localparam int               OUT_POS  = WIDTH - 1;
`endif

  state_t           r_state;
  logic [WIDTH-1:0] r_shift;
  logic [CNT_W-1:0] r_cnt;
  logic             r_serial_bit;
  logic             r_serial_valid;
  logic             r_serial_last;
  logic [CNT_W-1:0] r_bit_index;

  state_t           w_nxt_state;
  logic [WIDTH-1:0] w_nxt_shift;
  logic [CNT_W-1:0] w_nxt_cnt;
  logic             w_accept;
  logic             w_eow;
  logic             w_hold_wr;
  logic             w_hold_rd;
  logic             w_hold_full;
  logic [WIDTH-1:0] w_hold_data;

  // Advance the shift register by one bit toward the output position.
  function automatic logic [WIDTH-1:0] shift_step(input logic [WIDTH-1:0] s);
`ifdef BIT_SERIALIZER_LSB_FIRST_EN
    return s >> 1;
`else
    return s << 1;
`endif
  endfunction

  assign load_ready = ~w_hold_full & ~rst;
  assign w_accept   = load_valid & load_ready;
  assign w_eow      = (r_state == SHIFT) && (r_cnt == LAST_IDX);
  // Mid-word accepts park in the holding register; an accept on the
  // end-of-word edge (hold necessarily empty) goes straight to the shifter.
  assign w_hold_wr  = w_accept && (r_state == SHIFT) && !w_eow;
  assign w_hold_rd  = w_eow && w_hold_full;

  word_hold_reg #(
    .WIDTH (WIDTH)
  ) u_hold (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (w_hold_wr),
    .wr_data (load_data),
    .rd_en   (w_hold_rd),
    .rd_data (w_hold_data),
    .full    (w_hold_full)
  );

  // Next-state decode for the FSM, bit counter and shift register.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_shift = r_shift;
    w_nxt_cnt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_nxt_shift = load_data;
          w_nxt_cnt   = '0;
          w_nxt_state = SHIFT;
        end
      end
      SHIFT: begin
        if (w_eow) begin
          w_nxt_cnt = '0;
          if (w_hold_full) begin
            w_nxt_shift = w_hold_data;
          end else if (w_accept) begin
            w_nxt_shift = load_data;
          end else begin
            w_nxt_state = IDLE;
          end
        end else begin
          w_nxt_shift = shift_step(r_shift);
          w_nxt_cnt   = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_nxt_state = IDLE;
        w_nxt_cnt   = '0;
      end
    endcase
  end

  // FSM state plus registered serial outputs derived from the next state,
  // so every output changes on the same edge as the state it describes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= IDLE;
      r_shift        <= '0;
      r_cnt          <= '0;
      r_serial_bit   <= IDLE_BIT;
      r_serial_valid <= 1'b0;
      r_serial_last  <= 1'b0;
      r_bit_index    <= '0;
    end else begin
      r_state        <= w_nxt_state;
      r_shift        <= w_nxt_shift;
      r_cnt          <= w_nxt_cnt;
      r_serial_bit   <= (w_nxt_state == SHIFT) ? w_nxt_shift[OUT_POS] : IDLE_BIT;
      r_serial_valid <= (w_nxt_state == SHIFT);
      r_serial_last  <= (w_nxt_state == SHIFT) && (w_nxt_cnt == LAST_IDX);
      r_bit_index    <= (w_nxt_state == SHIFT) ? w_nxt_cnt : '0;
    end
  end

  assign serial_bit   = r_serial_bit;
  assign serial_valid = r_serial_valid;
  assign serial_last  = r_serial_last;
  assign bit_index    = r_bit_index;

endmodule

// File: tb/tb_bit_serializer.sv
// Directed testbench for bit_serializer with WIDTH=8.
// Honors BIT_SERIALIZER_LSB_FIRST_EN for the expected shift order.
module tb_bit_serializer;

  logic       clk;
  logic       rst;
  logic [7:0] load_data;
  logic       load_valid;
  logic       load_ready;
  logic       serial_bit;
  logic       serial_valid;
  logic       serial_last;
  logic [2:0] bit_index;

  int checks = 0;
  int errors = 0;

  bit_serializer #(
    .WIDTH    (8),
    .IDLE_BIT (1'b0)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .load_data    (load_data),
    .load_valid   (load_valid),
    .load_ready   (load_ready),
    .serial_bit   (serial_bit),
    .serial_valid (serial_valid),
    .serial_last  (serial_last),
    .bit_index    (bit_index)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Bit i of word w in transmission order.
  function automatic logic exp_bit(input logic [7:0] w, input int i);
`ifdef BIT_SERIALIZER_LSB_FIRST_EN
    return w[i];
`else
    return w[7-i];
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    load_valid = 1'b0;
    load_data = 8'h00;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (serial_valid !== 1'b0 || serial_bit !== 1'b0 || load_ready !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold cyc%0d: valid=%b bit=%b ready=%b, want 0 0 0",
                 c, serial_valid, serial_bit, load_ready);
      end
    end
    rst = 1'b0;
    tick();
    checks++;
    if (load_ready !== 1'b1 || serial_valid !== 1'b0 || serial_last !== 1'b0 || bit_index !== 3'd0) begin
      errors++;
      $display("FAIL reset_release: ready=%b valid=%b last=%b idx=%0d, want 1 0 0 0",
               load_ready, serial_valid, serial_last, bit_index);
    end
  endtask

  task automatic test_single_word();
    logic [7:0] w;
    w = 8'hA5;
    load_data = w;
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (serial_valid !== 1'b1 || serial_bit !== exp_bit(w, i) ||
          serial_last !== (i == 7) || bit_index !== 3'(i)) begin
        errors++;
        $display("FAIL single_bit%0d: valid=%b bit=%b last=%b idx=%0d, want 1 %b %b %0d",
                 i, serial_valid, serial_bit, serial_last, bit_index, exp_bit(w, i), (i == 7), i);
      end
      tick();
    end
    checks++;
    if (serial_valid !== 1'b0 || serial_bit !== 1'b0 || serial_last !== 1'b0 || bit_index !== 3'd0) begin
      errors++;
      $display("FAIL single_idle: valid=%b bit=%b last=%b idx=%0d, want 0 0 0 0",
               serial_valid, serial_bit, serial_last, bit_index);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] pair;
    logic        exp_b;
    logic        exp_rdy;
    pair = 16'h05A0;
    load_data = pair[15:8];
    load_valid = 1'b1;
    tick();
    load_data = pair[7:0];
    for (int j = 0; j < 16; j++) begin
      exp_b   = (j < 8) ? exp_bit(pair[15:8], j) : exp_bit(pair[7:0], j - 8);
      exp_rdy = (j == 0) || (j >= 8);
      checks++;
      if (serial_valid !== 1'b1 || serial_bit !== exp_b || load_ready !== exp_rdy ||
          serial_last !== (j == 7 || j == 15) || bit_index !== 3'(j % 8)) begin
        errors++;
        $display("FAIL b2b_bit%0d: valid=%b bit=%b ready=%b last=%b idx=%0d, want 1 %b %b %b %0d",
                 j, serial_valid, serial_bit, load_ready, serial_last, bit_index,
                 exp_b, exp_rdy, (j == 7 || j == 15), j % 8);
      end
      if (j == 1) load_valid = 1'b0;
      tick();
    end
    checks++;
    if (serial_valid !== 1'b0 || load_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_end: valid=%b ready=%b, want 0 1", serial_valid, load_ready);
    end
  endtask

  task automatic test_eow_accept();
    logic [7:0] w1;
    logic [7:0] w2;
    logic       exp_b;
    w1 = 8'h0F;
    w2 = 8'hC3;
    load_data = w1;
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    for (int j = 0; j < 16; j++) begin
      exp_b = (j < 8) ? exp_bit(w1, j) : exp_bit(w2, j - 8);
      checks++;
      if (serial_valid !== 1'b1 || serial_bit !== exp_b || load_ready !== 1'b1) begin
        errors++;
        $display("FAIL eow_accept_bit%0d: valid=%b bit=%b ready=%b, want 1 %b 1",
                 j, serial_valid, serial_bit, load_ready, exp_b);
      end
      if (j == 7) begin
        load_data = w2;
        load_valid = 1'b1;
      end else begin
        load_valid = 1'b0;
      end
      tick();
    end
    checks++;
    if (serial_valid !== 1'b0) begin
      errors++;
      $display("FAIL eow_accept_end: valid=%b, want 0", serial_valid);
    end
  endtask

  task automatic test_reset_midword();
    int leaks;
    load_data = 8'hFF;
    load_valid = 1'b1;
    tick();
    tick();
    load_valid = 1'b0;
    tick();
    tick();
    checks++;
    if (bit_index !== 3'd3 || serial_valid !== 1'b1 || load_ready !== 1'b0) begin
      errors++;
      $display("FAIL midrst_pre: idx=%0d valid=%b ready=%b, want 3 1 0",
               bit_index, serial_valid, load_ready);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (serial_valid !== 1'b0 || serial_bit !== 1'b0 || load_ready !== 1'b0 || bit_index !== 3'd0) begin
      errors++;
      $display("FAIL midrst_async: valid=%b bit=%b ready=%b idx=%0d, want 0 0 0 0",
               serial_valid, serial_bit, load_ready, bit_index);
    end
    tick();
    tick();
    rst = 1'b0;
    leaks = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (serial_valid !== 1'b0 || serial_bit !== 1'b0) leaks++;
    end
    checks++;
    if (leaks !== 0 || load_ready !== 1'b1) begin
      errors++;
      $display("FAIL midrst_discard: leak_cycles=%0d ready=%b, want 0 1", leaks, load_ready);
    end
  endtask

  task automatic test_detector_chain();
    logic h1;
    logic h0;
    int   hits;
    int   vcnt;
    h1 = 1'b0;
    h0 = 1'b0;
    hits = 0;
    vcnt = 0;
    load_data = 8'h55;
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (serial_valid === 1'b1) begin
        vcnt++;
        if (h1 === 1'b1 && h0 === 1'b0 && serial_bit === 1'b1) hits++;
        h1 = h0;
        h0 = serial_bit;
      end
      tick();
    end
    checks++;
    if (hits !== 3 || vcnt !== 8) begin
      errors++;
      $display("FAIL detector_chain: hits=%0d valid_cycles=%0d, want 3 8", hits, vcnt);
    end
  endtask

  task automatic test_order_01();
    logic [7:0] got;
    logic [7:0] want;
    load_data = 8'h01;
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    got = '0;
    want = '0;
    for (int i = 0; i < 8; i++) begin
      got[7-i]  = serial_bit;
      want[7-i] = exp_bit(8'h01, i);
      tick();
    end
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL order_01: stream=%b, want %b", got, want);
    end
  endtask

  initial begin
    rst = 1'b1;
    load_valid = 1'b0;
    load_data = 8'h00;
    test_reset();
    test_single_word();
    test_back_to_back();
    test_eow_accept();
    test_reset_midword();
    test_detector_chain();
    test_order_01();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bit_serializer.md
# bit_serializer

Word-to-bit serializer that sits directly upstream of the 101 sequence detector and drives its per-cycle serial input. It accepts WIDTH-bit words over a valid/ready handshake, holds up to one pending word in a holding register, and shifts one bit per clk onto serial_bit. Back-to-back words stream with no idle gap. The serial stream feeds the detector's input bit, and serial_valid marks live data.

## Interface
- WIDTH, 8: word width in bits; legal range 2..32.
- IDLE_BIT, 1'b0: level driven on serial_bit when no word is shifting.
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- load_data  in  WIDTH  word to serialize.
- load_valid  in  1  load_data is valid this cycle.
- load_ready  out  1  block can accept a word this cycle. Equals !hold_full && !rst.
- serial_bit  out  1  current serial bit, registered. Connects to the detector input bit.
- serial_valid  out  1  high while serial_bit carries word data.
- serial_last  out  1  high during the cycle that carries the final bit of a word.
- bit_index  out  $clog2(WIDTH)  index of the bit currently on serial_bit, counting from 0 in shift order.

## Operation
- State machine with two states.
  - IDLE: shifter empty.
  - SHIFT: word in the shift register; bit counter cnt runs 0..WIDTH-1.
- Accept rule: a word is accepted at a rising edge when load_valid && load_ready.
  - IDLE: the accepted word loads straight into the shift register, cnt=0, and the state moves to SHIFT.
  - SHIFT: the accepted word goes into the holding register and hold_full is set.
- Shift rule: in SHIFT, each edge advances the shift register by one bit and increments cnt.
  - Default order is MSB first.
- End of word (edge where cnt==WIDTH-1):
  - hold_full set: the held word moves into the shift register, cnt=0, state stays SHIFT, hold_full clears. No gap.
  - Else, accept on the same edge: the new word loads directly into the shift register, state stays SHIFT.
  - Else: state goes to IDLE.
- Outputs:
  - serial_bit = current shift-register output bit in SHIFT, IDLE_BIT in IDLE.
  - serial_valid = (state==SHIFT).
  - serial_last = SHIFT && cnt==WIDTH-1.
  - bit_index = cnt in SHIFT, 0 in IDLE.
- load_data is sampled only on an accepting edge. It is don't-care otherwise.
- load_valid may drop without an accept; no word is lost or duplicated.

## Timing
- Reset values (asserted, asynchronous):
  - state=IDLE, cnt=0, hold_full=0, shift register cleared.
  - serial_bit=IDLE_BIT, serial_valid=0, serial_last=0, bit_index=0.
  - load_ready=0 while rst is high; load_ready=1 from the first cycle after release.
- Latency: a word accepted at edge k in IDLE puts its first bit on serial_bit in the cycle after edge k. Its last bit is in the cycle after edge k+WIDTH-1.
- Throughput: one bit per clk, sustained. With load_valid held high, serial_valid stays continuously high.
- load_ready falls the cycle after a word enters the holding register. It rises the cycle after the end-of-word edge that drains the holding register.
- Reset mid-word: the shifting word and the held word are discarded. serial_valid=0 immediately. The detector downstream is reset on the same rst.
- Simultaneous accept and end-of-word with hold empty: the word goes to the shifter, not to hold.

## Configuration
- BIT_SERIALIZER_LSB_FIRST_EN
  - Defined: shift order is LSB first (load_data[0] appears first). bit_index 0 corresponds to load_data[0].
  - Undefined (default): MSB first (load_data[WIDTH-1] appears first). bit_index 0 corresponds to load_data[WIDTH-1].
  - Handshake and timing are identical either way.

## Structure
- Shared package bit_serializer_pkg holds:
  - state localparams IDLE and SHIFT;
  - the default IDLE_BIT constant.
- One sub-module, word_hold_reg: the single-entry holding register.
  - Ports: clk, rst, wr_en, wr_data, rd_en, rd_data, full.
  - Write and read in the same cycle is allowed only when full.
- Top level contains the FSM, the bit counter and the shift register.

## Test plan
All scenarios use WIDTH=8.
- Reset: assert rst for 3 cycles → serial_valid=0, serial_bit=0, load_ready=0 during reset. load_ready=1 on the first cycle after release.
- Single word: load 8'hA5 from IDLE → serial_bit 1,0,1,0,0,1,0,1 on the 8 cycles after accept. serial_valid high for exactly 8 cycles, serial_last on the 8th, then IDLE.
- Back-to-back: 8'h05 then 8'hA0 with load_valid held → 16 contiguous valid bits 00000101 10100000. load_ready low from the cycle after the second accept until the cycle after the first word's last bit.
- Reset at bit_index 3 with a word held → serial_valid=0 immediately. Neither the rest of the word nor the held word ever appears.
- Chained to the 101 detector: stream 8'h55 (01010101) → detector output high exactly 3 times.
- With BIT_SERIALIZER_LSB_FIRST_EN defined: load 8'h01 → first serial bit 1, remaining seven bits 0.
